// File: rtl/pdu_dma_fetch_if.sv
// Descriptor, ring-buffer read port and packet-stream signals of the PDU DMA fetch engine.
// slave = the fetch engine, master = its environment (ring buffer + PCIe TX).
interface pdu_dma_fetch_if #(
    parameter int PDU_AWIDTH    = 9,
    parameter int APP_IDX_WIDTH = 8,
    parameter int DATA_W        = 512
);
    logic                     dma_start;
    logic [PDU_AWIDTH-1:0]    dma_base_addr;
    logic [PDU_AWIDTH-1:0]    dma_size;
    logic [APP_IDX_WIDTH-1:0] dma_queue;
    logic                     dma_done;
    logic [PDU_AWIDTH-1:0]    rd_addr;
    logic                     rd_en;
    logic                     rd_valid;
    logic [DATA_W-1:0]        rd_data;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_sop;
    logic                     out_eop;
    logic [APP_IDX_WIDTH-1:0] out_queue;

    modport slave (
        input  dma_start, dma_base_addr, dma_size, dma_queue, rd_valid, rd_data, out_ready,
        output dma_done, rd_addr, rd_en, out_data, out_valid, out_sop, out_eop, out_queue
    );
    modport master (
        output dma_start, dma_base_addr, dma_size, dma_queue, rd_valid, rd_data, out_ready,
        input  dma_done, rd_addr, rd_en, out_data, out_valid, out_sop, out_eop, out_queue
    );
endinterface

// File: rtl/pdu_dma_fetch.sv
// Fetches one descriptor's flits from the 2-cycle ring buffer read port and streams them
// through a credit-controlled show-ahead skid FIFO; pulses dma_done after the last transfer.
module pdu_dma_fetch #(
    parameter int PDU_DEPTH     = 512,
    parameter int PDU_AWIDTH    = $clog2(PDU_DEPTH),
    parameter int APP_IDX_WIDTH = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    pdu_dma_fetch_if.slave   bus
);
    localparam int DATA_W = 512;
    localparam int FAW    = $clog2(FIFO_DEPTH);
    localparam int CW     = FAW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                   r_state;
    logic [PDU_AWIDTH-1:0]    r_base;
    logic [PDU_AWIDTH-1:0]    r_size;
    logic [PDU_AWIDTH-1:0]    r_issued;
    logic [PDU_AWIDTH-1:0]    r_popped;
    logic [APP_IDX_WIDTH-1:0] r_queue;
    logic [CW-1:0]            r_inflight;
    logic [CW-1:0]            r_count;
    logic [FAW-1:0]           r_wptr;
    logic [FAW-1:0]           r_rptr;
    logic [DATA_W-1:0]        r_mem [FIFO_DEPTH];
    logic                     r_done;

    logic                     w_rd_en;
    logic                     w_push;
    logic                     w_out_valid;
    logic                     w_pop;
    logic [PDU_AWIDTH-1:0]    w_popped_nxt;
    logic                     w_last_issue;

    // Credit: every issued read already owns a FIFO slot, so the FIFO can never overflow.
    assign w_rd_en      = !rst && (r_state == FETCH) &&
                          (({1'b0, r_inflight} + {1'b0, r_count}) < (CW+1)'(FIFO_DEPTH));
    assign w_push       = bus.rd_valid && (r_inflight != '0);
    assign w_out_valid  = !rst && (r_count != '0);
    assign w_pop        = w_out_valid && bus.out_ready;
    assign w_popped_nxt = r_popped + PDU_AWIDTH'(w_pop);
    assign w_last_issue = (r_issued + PDU_AWIDTH'(1)) == r_size;

    assign bus.rd_en     = w_rd_en;
    assign bus.rd_addr   = r_base + r_issued;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_mem[r_rptr];
    assign bus.out_sop   = w_out_valid && (r_popped == '0);
    assign bus.out_eop   = w_out_valid && (r_popped == r_size - PDU_AWIDTH'(1));
    assign bus.out_queue = r_queue;
    assign bus.dma_done  = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_size     <= '0;
            r_issued   <= '0;
            r_popped   <= '0;
            r_queue    <= '0;
            r_inflight <= '0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_done     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_done <= 1'b0;

            case ({w_rd_en, w_push})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: ;
            endcase

            if (w_push) begin
                r_mem[r_wptr] <= bus.rd_data;
                r_wptr        <= r_wptr + FAW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + FAW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase

            if (w_pop) r_popped <= w_popped_nxt;

            case (r_state)
                IDLE: if (bus.dma_start) begin
                    r_base   <= bus.dma_base_addr;
                    r_size   <= bus.dma_size;
                    r_queue  <= bus.dma_queue;
                    r_issued <= '0;
                    r_popped <= '0;
                    r_state  <= (bus.dma_size == '0) ? DRAIN : FETCH;
                end
                FETCH: if (w_rd_en) begin
                    r_issued <= r_issued + PDU_AWIDTH'(1);
                    if (w_last_issue) r_state <= DRAIN;
                end
                // Looking at the post-pop count puts dma_done exactly one cycle after the last transfer.
                DRAIN: if (w_popped_nxt == r_size) begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pdu_dma_fetch.sv
// Scoreboard bench for pdu_dma_fetch: a ring-buffer model answers reads, expected flits are
// queued per descriptor, and a negedge monitor checks every transfer, address and done pulse.
module tb_pdu_dma_fetch;
    localparam int AW = 9, QW = 8, DW = 512, FD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pdu_dma_fetch_if #(.PDU_AWIDTH(AW), .APP_IDX_WIDTH(QW), .DATA_W(DW)) bus();
    pdu_dma_fetch #(.PDU_DEPTH(512), .PDU_AWIDTH(AW), .APP_IDX_WIDTH(QW), .FIFO_DEPTH(FD))
        dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
        logic [QW-1:0] q;
    } flit_t;

    flit_t exp_q[$];
    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    int iss_cnt = 0, xfer_cnt = 0, max_occ = 0, cur_size = 0, last_xfer_cyc = 0;
    int pend_done = 0;
    int rmode = 0;
    logic [AW-1:0] nxt_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        for (int l = 0; l < 16; l++) w[l*32 +: 32] = {8'(l), 7'h5A, a, 8'hC3};
        return w;
    endfunction

    // Ring buffer: data returns two cycles after the request.
    logic [1:0]    rv = 2'b00;
    logic [AW-1:0] ra0 = '0, ra1 = '0;
    always @(posedge clk) begin
        rv  <= {rv[0], bus.rd_en};
        ra0 <= bus.rd_addr;
        ra1 <= ra0;
    end
    assign bus.rd_valid = rv[1];
    assign bus.rd_data  = mem_word(ra1);

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = !bus.out_ready;
                default: bus.out_ready = ($urandom % 10) < 7;
            endcase
        end
    end

    // Monitor
    logic          hold_prev = 1'b0;
    logic [DW-1:0] prev_d;
    logic          prev_sop, prev_eop;
    logic [QW-1:0] prev_q;
    initial begin
        flit_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev = 1'b0;
            end else begin
                if (bus.rd_en) begin
                    chk("rd_addr", bus.rd_addr, nxt_addr);
                    nxt_addr++;
                    iss_cnt++;
                end
                if (iss_cnt - xfer_cnt > max_occ) max_occ = iss_cnt - xfer_cnt;
                if (hold_prev) begin
                    chk("hold_valid", bus.out_valid, 1'b1);
                    chk("hold_data", bus.out_data, prev_d);
                    chk("hold_flags", {bus.out_sop, bus.out_eop, bus.out_queue}, {prev_sop, prev_eop, prev_q});
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_flit", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", bus.out_data, e.d);
                        chk("out_sop", bus.out_sop, e.sop);
                        chk("out_eop", bus.out_eop, e.eop);
                        chk("out_queue", bus.out_queue, e.q);
                    end
                    xfer_cnt++;
                    last_xfer_cyc = cyc;
                end
                hold_prev = bus.out_valid && !bus.out_ready;
                prev_d = bus.out_data; prev_sop = bus.out_sop; prev_eop = bus.out_eop; prev_q = bus.out_queue;
                if (bus.dma_done) begin
                    chk("done_expected", 32'(pend_done), 32'd1);
                    chk("done_queue_empty", 32'(exp_q.size()), 32'd0);
                    if (cur_size != 0) chk("done_gap", 32'(cyc - last_xfer_cyc), 32'd1);
                    pend_done = 0;
                end
            end
        end
    end

    task automatic start_desc(input int base, input int size, input int q, output int t0);
        flit_t e;
        @(posedge clk); #1;
        for (int i = 0; i < size; i++) begin
            e.d = mem_word(AW'(base + i)); e.sop = (i == 0); e.eop = (i == size - 1); e.q = QW'(q);
            exp_q.push_back(e);
        end
        nxt_addr = AW'(base); iss_cnt = 0; xfer_cnt = 0; max_occ = 0; cur_size = size; pend_done = 1;
        bus.dma_start = 1'b1; bus.dma_base_addr = AW'(base); bus.dma_size = AW'(size); bus.dma_queue = QW'(q);
        t0 = cyc;
        @(posedge clk); #1;
        bus.dma_start = 1'b0;
    endtask

    task automatic run_desc(input int base, input int size, input int q, input bit timed);
        int t0;
        bit got;
        start_desc(base, size, q, t0);
        got = 1'b0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clk);
            if (bus.dma_done) got = 1'b1;
        end
        if (!got) chk("done_timeout", 1'b0, 1'b1);
        else if (timed) chk("done_cycle", 32'(cyc), 32'(t0 + ((size == 0) ? 2 : 4 + size)));
        chk("rd_en_count", 32'(iss_cnt), 32'(size));
        chk("occupancy_le_depth", 32'(max_occ <= FD), 32'd1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_ctrl", {bus.dma_done, bus.rd_en, bus.out_valid, bus.out_sop, bus.out_eop}, 5'b0);
        chk("rst_rd_addr", bus.rd_addr, '0);
        chk("rst_out_queue", bus.out_queue, '0);
        chk("rst_out_data", bus.out_data, '0);
    endtask

    initial begin
        int t0, sz, bs;
        bit seen;
        bus.dma_start = 1'b0; bus.dma_base_addr = '0; bus.dma_size = '0; bus.dma_queue = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_vals();

        run_desc(12'h010, 2, 5, 1'b1);
        rmode = 1; run_desc(12'h100, 8, 3, 1'b0);
        rmode = 0; run_desc(0, 0, 7, 1'b1);
        run_desc(12'h000, 3, 1, 1'b1);
        run_desc(12'h003, 4, 2, 1'b1);
        run_desc(444, 4, 9, 1'b1);
        run_desc(0, 448, 8'hAA, 1'b1);

        // Abort a descriptor after three transfers; its in-flight reads come back stale.
        start_desc(12'h040, 8, 6, t0);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk); #1;
            if (xfer_cnt >= 3) seen = 1'b1;
        end
        chk("reset_test_reach3", seen, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1; exp_q.delete(); pend_done = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals();
        repeat (6) @(negedge clk);
        chk("no_stale_output", 32'(xfer_cnt), 32'd3);
        run_desc(12'h020, 2, 4, 1'b1);

        for (int n = 0; n < 25; n++) begin
            rmode = $urandom_range(0, 2);
            sz = $urandom_range(0, 24);
            bs = $urandom_range(0, 512 - sz);
            run_desc(bs, sz, $urandom_range(0, 255), rmode == 0);
        end
        rmode = 0;
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
